// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester and the PS/2 host transmitter.
// The master presents command bytes; the slave (transmitter) reports progress and results.
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       done;
   logic       error;
   logic [1:0] err_code;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, busy, done, error, err_code
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, busy, done, error, err_code
   );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, frame shift on device clock, ACK check.
// Define PS2_TX_RETRY_EN to restart a failed transfer automatically (up to 2 retries).
//
// state     | meaning
// ----------|------------------------------------------------------------
// IDLE      | bus released, waiting for a command byte
// INHIBIT   | holding PS/2 clock low for INHIBIT_CYCLES
// REQ       | start bit driven with clock still held, then clock released
// SHIFT     | data, parity and stop driven on each device clock fall
// ACK       | sampling the device ACK on the next fall
// WAIT_IDLE | waiting for clock and data to both return high
// FAIL      | lines released, error reported
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 10000,
   parameter int TIMEOUT_CYCLES = 2000000,
   parameter int FILTER_LEN     = 8
) (
   input  logic         clk,
   input  logic         rst,
   ps2_host_tx_if.slave host,
   input  logic         ps2_clk_in,
   input  logic         ps2_data_in,
   output logic         ps2_clk_oe,
   output logic         ps2_data_oe
);

   localparam int TMR_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int FLT_W   = $clog2(FILTER_LEN + 1);

   localparam logic [TMR_W-1:0] INHIBIT_LOAD = TMR_W'(INHIBIT_CYCLES - 1);
   localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [FLT_W-1:0] FLT_LAST     = FLT_W'(FILTER_LEN - 1);

   localparam logic [1:0] CODE_TIMEOUT = 2'b01;
   localparam logic [1:0] CODE_NOACK   = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      SHIFT,
      ACK,
      WAIT_IDLE,
      FAIL
   } state_t;

   state_t           state;
   logic             clk_s1, clk_s2;
   logic             data_s1, data_s2;
   logic             clk_filt;
   logic             fall;
   logic [FLT_W-1:0] flt_cnt;
   logic [TMR_W-1:0] timer;
   logic [3:0]       bit_cnt;
   logic [7:0]       tx_byte;
   logic             parity;
   logic [1:0]       pend_code;
   logic             line_idle;
   logic             fail_now;
   logic [1:0]       fail_kind;
`ifdef PS2_TX_RETRY_EN
   logic [1:0]       retry_cnt;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_s1  <= 1'b1;
         clk_s2  <= 1'b1;
         data_s1 <= 1'b1;
         data_s2 <= 1'b1;
      end else begin
         clk_s1  <= ps2_clk_in;
         clk_s2  <= clk_s1;
         data_s1 <= ps2_data_in;
         data_s2 <= data_s1;
      end
   end

   // A new clock level is accepted only after FILTER_LEN consecutive differing samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_filt <= 1'b1;
         flt_cnt  <= '0;
         fall     <= 1'b0;
      end else begin
         fall <= 1'b0;
         if (clk_s2 == clk_filt) begin
            flt_cnt <= '0;
         end else if (flt_cnt == FLT_LAST) begin
            clk_filt <= clk_s2;
            flt_cnt  <= '0;
            fall     <= clk_filt;
         end else begin
            flt_cnt <= flt_cnt + FLT_W'(1);
         end
      end
   end

   // A fall always beats an expiring timer, since the fall restarts the count.
   always_comb begin
      line_idle = clk_filt & data_s2;
      fail_now  = 1'b0;
      fail_kind = CODE_TIMEOUT;
      if (state == ACK && fall && data_s2) begin
         fail_now  = 1'b1;
         fail_kind = CODE_NOACK;
      end else if (!fall && timer == '0 &&
                   (state == SHIFT || state == ACK || (state == WAIT_IDLE && !line_idle))) begin
         fail_now  = 1'b1;
         fail_kind = CODE_TIMEOUT;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         tx_byte       <= '0;
         parity        <= 1'b0;
         bit_cnt       <= '0;
         timer         <= '0;
         pend_code     <= 2'b00;
         ps2_clk_oe    <= 1'b0;
         ps2_data_oe   <= 1'b0;
         host.tx_ready <= 1'b1;
         host.busy     <= 1'b0;
         host.done     <= 1'b0;
         host.error    <= 1'b0;
         host.err_code <= 2'b00;
`ifdef PS2_TX_RETRY_EN
         retry_cnt     <= '0;
`endif
      end else begin
         host.done  <= 1'b0;
         host.error <= 1'b0;
         if (fail_now) begin
`ifdef PS2_TX_RETRY_EN
            if (retry_cnt != 2'd2) begin
               retry_cnt   <= retry_cnt + 2'd1;
               state       <= INHIBIT;
               timer       <= INHIBIT_LOAD;
               ps2_clk_oe  <= 1'b1;
               ps2_data_oe <= 1'b0;
            end else begin
               state       <= FAIL;
               pend_code   <= fail_kind;
               ps2_clk_oe  <= 1'b0;
               ps2_data_oe <= 1'b0;
            end
`else
            state       <= FAIL;
            pend_code   <= fail_kind;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
`endif
         end else begin
            case (state)
               IDLE: begin
                  if (host.tx_valid && host.tx_ready) begin
                     tx_byte       <= host.tx_data;
                     parity        <= ~^host.tx_data;
                     timer         <= INHIBIT_LOAD;
                     ps2_clk_oe    <= 1'b1;
                     host.tx_ready <= 1'b0;
                     host.busy     <= 1'b1;
                     host.err_code <= 2'b00;
                     state         <= INHIBIT;
`ifdef PS2_TX_RETRY_EN
                     retry_cnt     <= '0;
`endif
                  end
               end
               INHIBIT: begin
                  if (timer == '0) begin
                     ps2_data_oe <= 1'b1;
                     state       <= REQ;
                  end else begin
                     timer <= timer - TMR_W'(1);
                  end
               end
               REQ: begin
                  ps2_clk_oe <= 1'b0;
                  bit_cnt    <= '0;
                  timer      <= TIMEOUT_LOAD;
                  state      <= SHIFT;
               end
               SHIFT: begin
                  if (fall) begin
                     timer   <= TIMEOUT_LOAD;
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt < 4'd8) begin
                        ps2_data_oe <= ~tx_byte[bit_cnt[2:0]];
                     end else if (bit_cnt == 4'd8) begin
                        ps2_data_oe <= ~parity;
                     end else begin
                        ps2_data_oe <= 1'b0;
                        state       <= ACK;
                     end
                  end else begin
                     timer <= timer - TMR_W'(1);
                  end
               end
               ACK: begin
                  if (fall) begin
                     timer <= TIMEOUT_LOAD;
                     state <= WAIT_IDLE;
                  end else begin
                     timer <= timer - TMR_W'(1);
                  end
               end
               WAIT_IDLE: begin
                  if (line_idle) begin
                     host.done     <= 1'b1;
                     host.busy     <= 1'b0;
                     host.tx_ready <= 1'b1;
                     state         <= IDLE;
                  end else if (fall) begin
                     timer <= TIMEOUT_LOAD;
                  end else begin
                     timer <= timer - TMR_W'(1);
                  end
               end
               FAIL: begin
                  host.error    <= 1'b1;
                  host.err_code <= pend_code;
                  host.busy     <= 1'b0;
                  host.tx_ready <= 1'b1;
                  state         <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized bench for ps2_host_tx with a PS/2 device model on wired-AND lines.
// Frames sampled by the device are compared against a frame built from the byte value.
module tb_ps2_host_tx;
   localparam int INH = 60;
   localparam int TMO = 500;
   localparam int FLT = 8;
`ifdef PS2_TX_RETRY_EN
   localparam int ATTEMPTS = 3;
`else
   localparam int ATTEMPTS = 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
   logic dev_clk  = 1'b1;
   logic dev_data = 1'b1;

   int n_chk = 0;
   int n_pass = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int inh_starts = 0;
   int inh_cycles = 0;
   logic [1:0] code_at_err = 2'b00;
   logic prev_clk_oe = 1'b0;

   ps2_host_tx_if host();

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TMO),
      .FILTER_LEN(FLT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .host(host),
      .ps2_clk_in(ps2_clk_in),
      .ps2_data_in(ps2_data_in),
      .ps2_clk_oe(ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe)
   );

   assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
   assign ps2_data_in = dev_data & ~ps2_data_oe;

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (host.done) done_cnt++;
      if (host.error) begin
         err_cnt++;
         code_at_err = host.err_code;
      end
      if (ps2_clk_oe && !prev_clk_oe) inh_starts++;
      if (ps2_clk_oe && !ps2_data_oe) inh_cycles++;
      prev_clk_oe = ps2_clk_oe;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start bit, 8 data bits LSB first, odd parity, stop bit.
   function automatic logic [10:0] ref_frame(input logic [7:0] d);
      logic [10:0] f;
      int ones;
      int v;
      ones = 0;
      v = int'(d);
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         f[i+1] = ((v / (1 << i)) % 2) == 1;
         ones += (v / (1 << i)) % 2;
      end
      f[9]  = (ones % 2) == 0;
      f[10] = 1'b1;
      return f;
   endfunction

   task automatic start_tx(input logic [7:0] d);
      int n;
      n = 0;
      while (!host.tx_ready && n < 100) begin
         tick();
         n++;
      end
      host.tx_data  = d;
      host.tx_valid = 1'b1;
      tick();
      host.tx_valid = 1'b0;
      check("acc_busy", host.busy, 1);
      check("acc_ready", host.tx_ready, 0);
   endtask

   task automatic wait_req(output bit ok);
      int n;
      n = 0;
      while (!(ps2_data_oe && !ps2_clk_oe) && n < INH + 40) begin
         tick();
         n++;
      end
      ok = ps2_data_oe && !ps2_clk_oe;
      check("req_seen", ok, 1);
   endtask

   // Device samples the data line at the end of each high phase, then drops the clock.
   task automatic dev_run(input int n, input int h, input bit ack_low, input int glitch,
                          output logic [10:0] samp);
      samp = '1;
      for (int k = 0; k < n; k++) begin
         for (int c = 0; c < h; c++) begin
            tick();
            if (k == glitch && c == 10) dev_clk = 1'b0;
            if (k == glitch && c == 13) dev_clk = 1'b1;
         end
         samp[k] = ps2_data_in;
         if (k == 10 && ack_low) dev_data = 1'b0;
         dev_clk = 1'b0;
         repeat (h) tick();
         dev_clk = 1'b1;
         if (k == 10) dev_data = 1'b1;
      end
   endtask

   task automatic serve(input int h, input bit ack_low, input int glitch, input bit poke,
                        input logic [7:0] d, output logic [10:0] samp, output bit ok);
      samp = '1;
      wait_req(ok);
      if (!ok) return;
      repeat (3) tick();
      if (poke) begin
         host.tx_data  = ~d;
         host.tx_valid = 1'b1;
         tick();
         host.tx_valid = 1'b0;
      end
      dev_run(11, h, ack_low, glitch, samp);
   endtask

   task automatic wait_evt(input int d0, input int e0, input int budget, output int cyc);
      cyc = 0;
      while (done_cnt == d0 && err_cnt == e0 && cyc < budget) begin
         tick();
         cyc++;
      end
      check("result_seen", (done_cnt != d0) || (err_cnt != e0), 1);
   endtask

   task automatic run_frame(input logic [7:0] d, input int h, input int glitch, input bit poke,
                            input string tag);
      int d0, e0, i0, s0, cyc;
      logic [10:0] samp;
      bit ok;
      d0 = done_cnt;
      e0 = err_cnt;
      i0 = inh_cycles;
      s0 = inh_starts;
      start_tx(d);
      serve(h, 1'b1, glitch, poke, d, samp, ok);
      if (ok) check({tag, "_frame"}, int'(samp), int'(ref_frame(d)));
      wait_evt(d0, e0, 200, cyc);
      repeat (30) tick();
      check({tag, "_done"}, done_cnt - d0, 1);
      check({tag, "_err"}, err_cnt - e0, 0);
      check({tag, "_inh_len"}, inh_cycles - i0, INH);
      check({tag, "_inh_cnt"}, inh_starts - s0, 1);
      check({tag, "_busy"}, host.busy, 0);
      check({tag, "_ready"}, host.tx_ready, 1);
      check({tag, "_code"}, host.err_code, 0);
      check({tag, "_oe"}, {ps2_clk_oe, ps2_data_oe}, 0);
   endtask

   initial begin
      int d0, e0, s0, cyc;
      logic [10:0] samp;
      bit ok;
      host.tx_valid = 1'b0;
      host.tx_data  = 8'h00;
      repeat (3) tick();
      check("rst_ready", host.tx_ready, 1);
      check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      rst = 1'b0;
      tick();
      check("idle_ready", host.tx_ready, 1);
      check("idle_busy", host.busy, 0);
      check("idle_pulses", {host.done, host.error}, 0);
      check("idle_code", host.err_code, 0);
      check("idle_oe", {ps2_clk_oe, ps2_data_oe}, 0);

      run_frame(8'hED, 20, -1, 1'b0, "ed");
      run_frame(8'h01, 18, -1, 1'b0, "x01");
      for (int i = 0; i < 6; i++)
         run_frame(8'($urandom_range(0, 255)), $urandom_range(16, 24), -1, 1'b0, "rand");
      run_frame(8'hA5, 20, 4, 1'b1, "glitch");

      // Device leaves data high on the ACK clock.
      d0 = done_cnt;
      e0 = err_cnt;
      s0 = inh_starts;
      start_tx(8'hFF);
      for (int a = 0; a < ATTEMPTS; a++) serve(20, 1'b0, -1, 1'b0, 8'hFF, samp, ok);
      wait_evt(d0, e0, 200, cyc);
      repeat (5) tick();
      check("noack_err", err_cnt - e0, 1);
      check("noack_done", done_cnt - d0, 0);
      check("noack_code_pulse", code_at_err, 2);
      check("noack_code_hold", host.err_code, 2);
      check("noack_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      check("noack_attempts", inh_starts - s0, ATTEMPTS);
      check("noack_ready", host.tx_ready, 1);

      // Device never clocks after the request.
      d0 = done_cnt;
      e0 = err_cnt;
      s0 = inh_starts;
      start_tx(8'hF4);
      wait_evt(d0, e0, ATTEMPTS * (INH + TMO + 20) + 50, cyc);
      repeat (2) tick();
      check("tmo_err", err_cnt - e0, 1);
      check("tmo_code", code_at_err, 1);
      check("tmo_not_early", cyc >= ATTEMPTS * (INH + TMO), 1);
      check("tmo_ready", host.tx_ready, 1);
      check("tmo_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      check("tmo_attempts", inh_starts - s0, ATTEMPTS);

      // Reset after the 4th device clock fall.
      d0 = done_cnt;
      e0 = err_cnt;
      start_tx(8'h00);
      wait_req(ok);
      if (ok) begin
         repeat (3) tick();
         dev_run(3, 20, 1'b0, -1, samp);
         repeat (20) tick();
         dev_clk = 1'b0;
         repeat (16) tick();
         check("prerst_data_oe", ps2_data_oe, 1);
         rst = 1'b1;
         #1;
         check("rst_mid_oe", {ps2_clk_oe, ps2_data_oe}, 0);
         dev_clk = 1'b1;
         repeat (5) tick();
         check("rst_mid_ready", host.tx_ready, 1);
         check("rst_mid_busy", host.busy, 0);
         rst = 1'b0;
         repeat (30) tick();
         check("rst_mid_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
      end
      run_frame(8'h5A, 22, -1, 1'b0, "after_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
